cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
Sits directly downstream of the cache controller's memory-side interface (downstream_read/downstream_write/downstream_resp) and upstream of physical memory. It converts one full-cacheline read or write into a sequence of fixed-width bursts. Reads assemble incoming beats into a line buffer. Writes capture the line once and stream it out beat by beat. Completion is signalled back to the cache with a single-cycle response.

Parameters:
LINE_WIDTH, 256, cacheline width in bits
BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be an integer multiple
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
address_i  in  ADDR_WIDTH  line address from cache
read_i  in  1  line read request; held until resp_o
write_i  in  1  line write request; held until resp_o
line_i  in  LINE_WIDTH  write data line; sampled at request acceptance
line_o  out  LINE_WIDTH  assembled read line
resp_o  out  1  one-cycle completion pulse
address_o  out  ADDR_WIDTH  line-aligned address to memory
read_o  out  1  burst read request to memory
write_o  out  1  burst write request to memory
burst_i  in  BURST_WIDTH  read beat from memory
burst_o  out  BURST_WIDTH  write beat to memory
resp_i  in  1  memory beat strobe; one beat transferred per cycle high

Behaviour:
- Derived values: BEATS = LINE_WIDTH/BURST_WIDTH; OFFSET = log2(LINE_WIDTH/8). The beat counter is log2(BEATS) bits wide, minimum 1.
- Reset (asynchronous, reset_n=0):
  - state=IDLE; beat counter=0; line buffer=0; latched address=0.
  - All outputs are 0 and take effect immediately, including mid-transfer; no partial beat is retained.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs read_o=write_o=resp_o=0.
  - If read_i=1: latch {address_i[ADDR_WIDTH-1:OFFSET], OFFSET'0}, clear the counter, go to READ.
  - Else if write_i=1: latch the address the same way, latch line_i into the buffer, clear the counter, go to WRITE.
  - Read has priority when read_i and write_i are both high; that case is illegal upstream and is flagged by a bench assertion.
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1; address_o = latched address.
  - Each cycle with resp_i=1: buffer[counter*BURST_WIDTH +: BURST_WIDTH] <= burst_i and the counter increments.
  - Beats may be non-consecutive; cycles with resp_i=0 hold all state.
  - On the beat where counter==BEATS-1: go to DONE and wrap the counter to 0.
- WRITE:
  - write_o=1; address_o = latched address; burst_o = buffer slice at the current counter.
  - Each resp_i=1 cycle advances the counter. The last beat goes to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; address_o holds.
  - read_i/write_i are ignored in this cycle, because upstream deasserts combinationally on resp_o. Next state is IDLE.
- Latency:
  - A request is accepted one cycle after assertion in IDLE.
  - resp_o is asserted the cycle after the final resp_i beat.
  - Minimum total latency is BEATS+2 cycles.
- line_o is driven from the buffer at all times. It is guaranteed valid only during resp_o of a read and holds until the next request is accepted.
- Upstream changes to address_i or line_i after acceptance have no effect.
- burst_o is 0 outside WRITE.

Decomposition:
- Shared package (rv32i_types or a cache package): LINE_WIDTH, BURST_WIDTH, and the state enum cl_adaptor_state_t {IDLE, READ, WRITE, DONE}.
- No sub-module is needed. Buffer, counter and FSM are compact enough to live in one module, using a separate next-state always_comb and an always_ff with asynchronous reset.

Test Plan:
- Read, consecutive beats:
  - Stimulus: read_i, address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles.
  - Required: address_o=0x0000_1220; read_o high through the last beat; resp_o 1 cycle after it; line_o = {44..,33..,22..,11..}.
- Write:
  - Stimulus: write_i, line_i = {D,C,B,A} (64-bit each).
  - Required: write_o=1; burst_o = A,B,C,D in order across 4 resp_i cycles; resp_o pulse after D; write_o=0 in DONE.
- Stalled beats:
  - Stimulus: read with resp_i pattern 1,0,0,1,1,0,1.
  - Required: beats stored only on high cycles; resp_o the cycle after the 7th; line_o correct.
- Mid-transfer reset:
  - Stimulus: reset_n=0 after 2 write beats.
  - Required: write_o, burst_o and address_o are 0 in the same cycle. After release, a new read completes normally with the counter starting at slice 0.
- Back-to-back requests and spurious strobes:
  - Stimulus: write then an immediate read; resp_i pulsed while IDLE.
  - Required: read accepted one cycle after DONE; IDLE resp_i causes no state change and no resp_o.
- Simultaneous request:
  - Stimulus: read_i=write_i=1.
  - Required: READ is entered and the bench assertion fires.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared widths and FSM state type for the cacheline adaptor
package cacheline_adaptor_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} cl_adaptor_state_t;

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: splits one cacheline read/write into fixed-width memory bursts
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = cacheline_adaptor_pkg::LINE_WIDTH,
  parameter int BURST_WIDTH = cacheline_adaptor_pkg::BURST_WIDTH,
  parameter int ADDR_WIDTH  = cacheline_adaptor_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic                   resp_i
);
  import cacheline_adaptor_pkg::*;

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CW     = cnt_width(BEATS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  cl_adaptor_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [LINE_WIDTH-1:0] buffer;
  logic [ADDR_WIDTH-1:0] addr;
  logic beat, last, accept;

  always_comb begin
    accept = (state == IDLE) && (read_i || write_i);
    beat = resp_i && (state == READ || state == WRITE);
    last = beat && (cnt == LAST);
    state_next = (state == IDLE) ? (read_i ? READ : write_i ? WRITE : IDLE) :
                 (state == DONE) ? IDLE :
                 last ? DONE : state;
  end

  always_comb begin
    read_o = (state == READ);
    write_o = (state == WRITE);
    resp_o = (state == DONE);
    address_o = addr;
    line_o = buffer;
    burst_o = write_o ? buffer[cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  end

  // read priority on accept: a simultaneous request never loads line_i
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      buffer <= '0;
      addr <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr <= address_i & ALIGN;
        cnt <= '0;
        if (!read_i) buffer <= line_i;
      end else if (beat) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == READ) buffer[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
      end
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: randomized scoreboard bench for the cacheline adaptor
module tb_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int BEATS = LW / BW;
  localparam int LINE_BYTES = LW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] address_i = '0;
  logic read_i = 1'b0;
  logic write_i = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic resp_o;
  logic [AW-1:0] address_o;
  logic read_o;
  logic write_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic resp_i = 1'b0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
  );

  typedef struct {
    bit rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  txn_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int illegal_cnt = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // upstream protocol guard: both requests together is illegal
  always @(posedge clk)
    if (reset_n && read_i && write_i && !read_o && !write_o && !resp_o) begin
      illegal_cnt++;
      $display("bench assertion: simultaneous read_i/write_i request at %0t", $time);
    end

  // monitor: compares every DUT-presented beat and completion against the queue head
  initial begin
    int idx;
    bit final_prev;
    bit resp_prev;
    idx = 0;
    final_prev = 0;
    resp_prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        idx = 0;
        final_prev = 0;
        resp_prev = 0;
        exp_q.delete();
        continue;
      end
      if (resp_o) begin
        chk("resp_single_cycle", LW'(resp_prev), '0);
        chk("resp_after_last_beat", LW'(final_prev), LW'(1));
        chk("done_outputs_quiet", LW'({read_o, write_o, |burst_o}), '0);
        chk("txn_pending_at_resp", LW'(exp_q.size() != 0), LW'(1));
        if (exp_q.size() != 0) begin
          if (exp_q[0].rd) chk("read_line", line_o, exp_q[0].line);
          chk("done_addr", LW'(address_o), LW'(exp_q[0].addr));
          void'(exp_q.pop_front());
        end
        idx = 0;
      end
      final_prev = 0;
      if (read_o || write_o) begin
        chk("txn_pending_when_busy", LW'(exp_q.size() != 0), LW'(1));
        if (exp_q.size() != 0) begin
          chk("mode", LW'({read_o, write_o}), LW'({exp_q[0].rd, !exp_q[0].rd}));
          chk("address_o", LW'(address_o), LW'(exp_q[0].addr));
          if (write_o) chk("burst_o", LW'(burst_o), LW'(exp_q[0].line[idx*BW +: BW]));
          if (resp_i) begin
            final_prev = (idx == BEATS - 1);
            idx++;
          end
        end
      end else if (!resp_o) begin
        chk("burst_zero_idle", LW'(burst_o), '0);
      end
      resp_prev = resp_o;
    end
  end

  // issue one line transfer; pat/plen gives the resp_i pattern, then strobes every cycle
  task automatic run_txn(input bit rd, input bit both, input logic [AW-1:0] addr,
                         input logic [LW-1:0] line, input logic [15:0] pat, input int plen);
    txn_t t;
    int beat;
    int cyc;
    bit r;
    t.rd = rd;
    t.addr = addr / LINE_BYTES * LINE_BYTES;
    t.line = line;
    exp_q.push_back(t);
    read_i = rd;
    write_i = !rd || both;
    address_i = addr;
    line_i = rd ? rand_line() : line;
    @(posedge clk); #1;
    chk("accept_latency", LW'(rd ? read_o : write_o), LW'(1));
    address_i = $urandom;
    line_i = rand_line();
    beat = 0;
    cyc = 0;
    while (beat < BEATS && cyc < 64) begin
      r = (cyc < plen) ? pat[cyc] : 1'b1;
      resp_i = r;
      burst_i = (r && rd) ? line[beat*BW +: BW] : {$urandom, $urandom};
      @(posedge clk); #1;
      if (r) beat++;
      cyc++;
    end
    resp_i = 1'b0;
    chk("beats_in_budget", LW'(beat), LW'(BEATS));
    read_i = 1'b0;
    write_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [LW-1:0] l;
    #1;
    chk("reset_outputs", LW'({read_o, write_o, resp_o, address_o, burst_o}), '0);
    chk("reset_line", line_o, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(1, 0, 32'h0000_1234, l, 16'hFFFF, 16);

    l = {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
         64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001};
    run_txn(0, 0, 32'h0000_8040, l, 16'hFFFF, 16);

    run_txn(1, 0, 32'h0000_2000, rand_line(), 16'b1011001, 7);

    // reset in the middle of a write
    exp_q.push_back('{rd: 1'b0, addr: 32'h0000_3000, line: rand_line()});
    write_i = 1'b1;
    address_i = 32'h0000_3000;
    line_i = exp_q[0].line;
    @(posedge clk); #1;
    resp_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resp_i = 1'b0;
    reset_n = 1'b0;
    write_i = 1'b0;
    #1;
    chk("midreset_outputs", LW'({read_o, write_o, resp_o, address_o, burst_o}), '0);
    chk("midreset_line", line_o, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_txn(1, 0, 32'h0000_4444, rand_line(), 16'hFFFF, 16);

    run_txn(0, 0, 32'h0000_5000, rand_line(), 16'hFFFF, 16);
    run_txn(1, 0, 32'h0000_5020, rand_line(), 16'hFFFF, 16);

    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("spurious_idle", LW'({read_o, write_o, resp_o}), '0);
    end
    resp_i = 1'b0;

    run_txn(1, 1, 32'h0000_6060, rand_line(), 16'hFFFF, 16);
    chk("illegal_flagged", LW'(illegal_cnt), LW'(1));

    for (int n = 0; n < 16; n++)
      run_txn(1'($urandom_range(0, 1)), 0, $urandom, rand_line(), 16'($urandom), 16);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", LW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
